// File: rtl/pc_ctrl.sv
// pc_ctrl -- fetch-stage sequencer.
//
// Owns the architectural PC. Each cycle it advances sequentially, holds (load-use
// stall or instruction memory busy), or redirects to an EX-stage branch/jump
// target. It also produces the IF/ID and ID/EX flush strobes.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   stall          load-use hold from the hazard unit
//   imem_ready     instruction memory returned the word for the current pc
//   ex_redirect    EX holds a valid control-transfer instruction
//   ex_npc_op      next-PC select from EX (PC_4 / PC_IMM / RD1_IMM)
//   ex_pc          PC of the EX instruction
//   ex_offset      sign-extended branch/jal offset
//   ex_alu_c       ALU result, used as the jalr target
//   pc             registered fetch address
//   pc4            pc + 4 (combinational)
//   fetch_valid    IF/ID may capture the fetched word this cycle
//   flush_ifid     invalidate IF/ID on the next edge
//   flush_idex     invalidate ID/EX on the next edge

module pc_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BOOT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        ex_redirect,
  input  logic [1:0]  ex_npc_op,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_offset,
  input  logic [31:0] ex_alu_c,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        fetch_valid,
  output logic        flush_ifid,
  output logic        flush_idex
);

  // next-PC select encodings shared with the EX stage
  localparam logic [1:0] PC_4    = 2'b00;
  localparam logic [1:0] PC_IMM  = 2'b01;
  localparam logic [1:0] RD1_IMM = 2'b10;

  // Boot counter only has to reach BOOT_CYCLES-1. With BOOT_CYCLES==0 the BOOT
  // state is never entered, so the wrapped LAST value is harmless.
  localparam int          CW   = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BOOT_CYCLES - 1);

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    RUN        = 2'd1,
    REDIR_WAIT = 2'd2
  } state_t;

  localparam state_t RST_STATE = (BOOT_CYCLES == 0) ? RUN : BOOT;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          take;
  logic [31:0]   target;

  // PC_4 and the unused code 2'b11 never redirect.
  assign take = ex_redirect && ((ex_npc_op == PC_IMM) || (ex_npc_op == RD1_IMM));

  // Branch/jal targets are used as computed; jalr clears bit 0.
  always_comb begin
    target = ex_pc + ex_offset;
    if (ex_npc_op == RD1_IMM) target = ex_alu_c & 32'hFFFF_FFFE;
  end

  assign pc  = pc_q;
  assign pc4 = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    fetch_valid = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    case (state_q)
      BOOT: begin
        // inputs ignored; pc stays at RESET_PC
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (take) begin
          // Redirect wins over stall: the stalled younger instruction is
          // on the wrong path anyway.
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          if (imem_ready) begin
            fetch_valid = 1'b1;   // word is killed by flush_ifid
            pc_d        = target;
          end else begin
            // fetch in flight: keep pc stable, apply target when it lands
            pend_d  = target;
            state_d = REDIR_WAIT;
          end
        end else if (stall) begin
          // hold and refetch the same pc, even if the word arrived
        end else if (imem_ready) begin
          fetch_valid = 1'b1;
          pc_d        = pc4;
        end
      end
      REDIR_WAIT: begin
        // EX holds a bubble here, so stall/ex_redirect are don't-care.
        flush_ifid = 1'b1;
        if (imem_ready) begin
          pc_d    = pend_q;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

endmodule
